impulse_analyzer: RTL and testbench
===================================

Name: impulse_analyzer

Overview:
Post-capture stage downstream of the impulse recorder. After a full impulse is written to impulse memory, this block scans the memory at full clock rate. It finds the peak magnitude and its index, the onset index (first sample reaching a fraction of the peak), and a power-of-two normalization gain. The convolution/playback stage then uses onset_index_out as its read base and gain_shift_out as its input scaling.

Parameters:
IMPULSE_LENGTH, 48000, number of samples stored in impulse memory (addresses 0..IMPULSE_LENGTH-1)
ADDR_WIDTH, 16, width of read_addr_out and all index outputs
READ_LATENCY, 2, clock cycles from read_addr_out to valid read_data_in
THRESHOLD_SHIFT, 3, onset threshold = peak_mag >> THRESHOLD_SHIFT

Ports:
audio_clk  input  1  system audio clock
rst_in  input  1  asynchronous reset, active-low
start_in  input  1  one-cycle pulse; impulse memory is complete (driven from the recorder's impulse_recorded rising edge)
read_addr_out  output  ADDR_WIDTH  impulse memory read address
read_data_in  input  16  signed sample returned READ_LATENCY cycles after its address
busy_out  output  1  high from the cycle after an accepted start until done
done_out  output  1  one-cycle pulse when results are valid
results_valid_out  output  1  high while result outputs hold a completed analysis
peak_mag_out  output  16  unsigned peak |sample|, range 0..32768
peak_index_out  output  ADDR_WIDTH  address of the first sample attaining peak_mag_out
onset_index_out  output  ADDR_WIDTH  first address with |sample| >= threshold
gain_shift_out  output  4  largest s in 0..15 with (peak_mag_out << s) <= 32767
silent_out  output  1  peak_mag_out == 0

Behaviour:
- Reset (rst_in low, async): every output is 0, the state is IDLE, and the pipeline valid bits are cleared. A reset mid-scan aborts the scan and does not produce done_out.
- States:
  - IDLE -> PEAK_SCAN on start_in; results_valid_out clears in the same edge.
  - PEAK_SCAN issues addresses 0..IMPULSE_LENGTH-1, one per cycle, then goes to PEAK_DRAIN.
  - PEAK_DRAIN waits READ_LATENCY cycles for the last data, then goes to ONSET_SCAN.
  - ONSET_SCAN issues from address 0 upward, then goes to ONSET_DRAIN.
  - ONSET_DRAIN goes to FINISH.
  - FINISH pulses done_out and sets results_valid_out, then goes to IDLE.
- Read pipeline: a READ_LATENCY-deep shift register carries {valid, addr} alongside each issued address. Only returned data tagged valid is evaluated. read_addr_out is 0 in IDLE.
- Magnitude: |x| is computed in 16-bit unsigned, so -32768 -> 32768.
- Peak update uses strict greater-than. Ties keep the earlier index.
- Threshold is latched at the PEAK_DRAIN -> ONSET_SCAN transition.
- Onset hit is the first valid returned sample with mag >= threshold. On a hit:
  - onset is latched and issuing stops immediately;
  - in-flight reads are discarded;
  - the state goes to ONSET_DRAIN, which lasts READ_LATENCY cycles.
- If peak_mag is 0, the threshold is 0, so address 0 hits. Result: onset 0, gain_shift 0, silent_out 1.
- Gain: peak 32768 -> 0; peak 1 -> 14; peak 0 -> 0. Computation is combinational from the latched peak and registered in FINISH.
- start_in while busy_out is ignored. start_in in the FINISH cycle is ignored.
- Latency: done_out occurs no later than 2*(IMPULSE_LENGTH+READ_LATENCY)+3 cycles after start_in.
- Outputs hold until the next accepted start_in.

Decomposition:
- Shared package impulse_pkg:
  - analyzer state enum (IDLE, PEAK_SCAN, PEAK_DRAIN, ONSET_SCAN, ONSET_DRAIN, FINISH);
  - constant SAMPLE_WIDTH=16;
  - constant MAX_POS_SAMPLE=32767.
- One sub-module: gain_shift_calc, a combinational 16-bit leading-zero-based shift computation. Unit-tested on its own.

Test Plan:
All scenarios use IMPULSE_LENGTH=16, READ_LATENCY=2 and a behavioural memory model.
- Memory all zero, start pulse -> done after <=39 cycles; peak 0, onset 0, gain 0, silent 1.
- Samples: addr5=+100, addr9=-400, others 10 -> peak 400, peak_index 9, threshold 50, onset 5, gain 6, silent 0.
- addr3=-32768, addr7=+32767 -> peak 32768, index 3, gain 0.
- Equal peaks +2000 at addr4 and addr11 -> peak_index 4.
- Second start during scan ignored; rst_in low mid-ONSET_SCAN -> all outputs 0, no done. A restart then completes correctly.
- Single +1 at addr15 -> peak 1, index 15, onset 15, gain 14. read_addr_out increments 0..15 contiguously in PEAK_SCAN.

Source files
------------

// File: rtl/impulse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | impulse_pkg                                                          |
// | Shared types and constants for the impulse analysis stage.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package impulse_pkg;

    localparam int SAMPLE_WIDTH   = 16;
    localparam int MAX_POS_SAMPLE = 32767;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PEAK_SCAN   = 3'd1,
        PEAK_DRAIN  = 3'd2,
        ONSET_SCAN  = 3'd3,
        ONSET_DRAIN = 3'd4,
        FINISH      = 3'd5
    } analyzer_state_t;

endpackage
`default_nettype wire

// File: rtl/gain_shift_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gain_shift_calc                                                      |
// | Largest left shift keeping a peak magnitude within positive range.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gain_shift_calc
    import impulse_pkg::*;
(
    input  logic [SAMPLE_WIDTH-1:0] mag,
    output logic [3:0]              shift
);

    logic [3:0] w_msb;

    // Zero and full-scale (32768) magnitudes cannot be amplified and map to 0.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < SAMPLE_WIDTH - 1; i++) begin
            if (mag[i]) begin
                w_msb = 4'(i);
            end
        end
        shift = '0;
        if (mag != '0 && mag <= SAMPLE_WIDTH'(MAX_POS_SAMPLE)) begin
            shift = 4'(SAMPLE_WIDTH - 2) - w_msb;
        end
    end

endmodule
`default_nettype wire

// File: rtl/impulse_analyzer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | impulse_analyzer                                                     |
// | Scans impulse memory for peak, onset index and normalization gain.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module impulse_analyzer
    import impulse_pkg::*;
#(
    parameter int IMPULSE_LENGTH  = 48000,
    parameter int ADDR_WIDTH      = 16,
    parameter int READ_LATENCY    = 2,
    parameter int THRESHOLD_SHIFT = 3
) (
    input  logic                           audio_clk,
    input  logic                           rst_in,
    input  logic                           start_in,
    output logic [ADDR_WIDTH-1:0]          read_addr_out,
    input  logic signed [SAMPLE_WIDTH-1:0] read_data_in,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           results_valid_out,
    output logic [SAMPLE_WIDTH-1:0]        peak_mag_out,
    output logic [ADDR_WIDTH-1:0]          peak_index_out,
    output logic [ADDR_WIDTH-1:0]          onset_index_out,
    output logic [3:0]                     gain_shift_out,
    output logic                           silent_out
);

    localparam int                    CNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(IMPULSE_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

    analyzer_state_t           r_state;
    logic                      r_issuing;
    logic [READ_LATENCY-1:0]   r_pipe_valid;
    logic [ADDR_WIDTH-1:0]     r_pipe_addr [READ_LATENCY];
    logic [CNT_W-1:0]          r_drain_cnt;
    logic [SAMPLE_WIDTH-1:0]   r_peak_mag;
    logic [SAMPLE_WIDTH-1:0]   r_threshold;
    logic [ADDR_WIDTH-1:0]     r_peak_idx;
    logic [ADDR_WIDTH-1:0]     r_onset_idx;

    logic                      w_ret_valid;
    logic [ADDR_WIDTH-1:0]     w_ret_addr;
    logic [SAMPLE_WIDTH-1:0]   w_mag;
    logic                      w_peak_upd;
    logic [SAMPLE_WIDTH-1:0]   w_peak_next;
    logic                      w_onset_hit;
    logic [3:0]                w_gain_shift;

    assign w_ret_valid = r_pipe_valid[READ_LATENCY-1];
    assign w_ret_addr  = r_pipe_addr[READ_LATENCY-1];
    // Unsigned magnitude so that -32768 maps to 32768 rather than wrapping.
    assign w_mag       = read_data_in[SAMPLE_WIDTH-1] ? SAMPLE_WIDTH'(-read_data_in)
                                                      : SAMPLE_WIDTH'(read_data_in);
    assign w_peak_upd  = w_ret_valid && (r_state == PEAK_SCAN || r_state == PEAK_DRAIN)
                         && (w_mag > r_peak_mag);
    assign w_peak_next = w_peak_upd ? w_mag : r_peak_mag;
    assign w_onset_hit = w_ret_valid && (r_state == ONSET_SCAN) && (w_mag >= r_threshold);

    gain_shift_calc u_gain_shift_calc (
        .mag   (r_peak_mag),
        .shift (w_gain_shift)
    );

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state           <= IDLE;
            r_issuing         <= 1'b0;
            r_pipe_valid      <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
            r_drain_cnt       <= '0;
            r_peak_mag        <= '0;
            r_threshold       <= '0;
            r_peak_idx        <= '0;
            r_onset_idx       <= '0;
            read_addr_out     <= '0;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            results_valid_out <= 1'b0;
            peak_mag_out      <= '0;
            peak_index_out    <= '0;
            onset_index_out   <= '0;
            gain_shift_out    <= '0;
            silent_out        <= 1'b0;
        end else begin
            done_out        <= 1'b0;
            r_pipe_valid[0] <= r_issuing;
            r_pipe_addr[0]  <= read_addr_out;
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end
            if (w_peak_upd) begin
                r_peak_mag <= w_mag;
                r_peak_idx <= w_ret_addr;
            end

            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_state           <= PEAK_SCAN;
                        r_issuing         <= 1'b1;
                        read_addr_out     <= '0;
                        busy_out          <= 1'b1;
                        results_valid_out <= 1'b0;
                        r_peak_mag        <= '0;
                        r_peak_idx        <= '0;
                    end
                end
                PEAK_SCAN: begin
                    if (read_addr_out == LAST_ADDR) begin
                        r_state       <= PEAK_DRAIN;
                        r_issuing     <= 1'b0;
                        read_addr_out <= '0;
                        r_drain_cnt   <= '0;
                    end else begin
                        read_addr_out <= read_addr_out + ADDR_ONE;
                    end
                end
                PEAK_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        // The final sample is still being folded in on this edge.
                        r_state     <= ONSET_SCAN;
                        r_threshold <= w_peak_next >> THRESHOLD_SHIFT;
                        r_issuing   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_ONE;
                    end
                end
                ONSET_SCAN: begin
                    if (w_onset_hit) begin
                        r_onset_idx   <= w_ret_addr;
                        r_state       <= ONSET_DRAIN;
                        r_issuing     <= 1'b0;
                        r_pipe_valid  <= '0;
                        read_addr_out <= '0;
                        r_drain_cnt   <= '0;
                    end else if (r_issuing) begin
                        if (read_addr_out == LAST_ADDR) begin
                            r_issuing     <= 1'b0;
                            read_addr_out <= '0;
                        end else begin
                            read_addr_out <= read_addr_out + ADDR_ONE;
                        end
                    end else if (r_pipe_valid == '0) begin
                        // Only reachable if memory changed between passes.
                        r_onset_idx <= '0;
                        r_state     <= ONSET_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                ONSET_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state           <= FINISH;
                        done_out          <= 1'b1;
                        busy_out          <= 1'b0;
                        results_valid_out <= 1'b1;
                        peak_mag_out      <= r_peak_mag;
                        peak_index_out    <= r_peak_idx;
                        onset_index_out   <= r_onset_idx;
                        gain_shift_out    <= w_gain_shift;
                        silent_out        <= (r_peak_mag == '0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_ONE;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_impulse_analyzer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_impulse_analyzer                                                  |
// | Randomized bench for impulse_analyzer against a behavioural model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_impulse_analyzer;

    localparam int LEN = 16;
    localparam int LAT = 2;
    localparam int AW  = 16;
    localparam int MAX_CYCLES = 2 * (LEN + LAT) + 3;

    logic               audio_clk = 1'b0;
    logic               rst_in;
    logic               start_in;
    logic [AW-1:0]      read_addr_out;
    logic signed [15:0] read_data_in;
    logic               busy_out, done_out, results_valid_out, silent_out;
    logic [15:0]        peak_mag_out;
    logic [AW-1:0]      peak_index_out, onset_index_out;
    logic [3:0]         gain_shift_out;

    logic signed [15:0] mem [LEN];
    logic signed [15:0] d1, d2;
    logic [15:0]        gsc_mag;
    logic [3:0]         gsc_shift;

    int n_checks = 0;
    int n_fail   = 0;

    impulse_analyzer #(
        .IMPULSE_LENGTH  (LEN),
        .ADDR_WIDTH      (AW),
        .READ_LATENCY    (LAT),
        .THRESHOLD_SHIFT (3)
    ) dut (
        .audio_clk         (audio_clk),
        .rst_in            (rst_in),
        .start_in          (start_in),
        .read_addr_out     (read_addr_out),
        .read_data_in      (read_data_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .results_valid_out (results_valid_out),
        .peak_mag_out      (peak_mag_out),
        .peak_index_out    (peak_index_out),
        .onset_index_out   (onset_index_out),
        .gain_shift_out    (gain_shift_out),
        .silent_out        (silent_out)
    );

    gain_shift_calc u_gsc (
        .mag   (gsc_mag),
        .shift (gsc_shift)
    );

    always #5 audio_clk = ~audio_clk;

    // Two-cycle registered memory read.
    always @(posedge audio_clk) begin
        d1 <= (int'(read_addr_out) < LEN) ? mem[read_addr_out] : 16'sd0;
        d2 <= d1;
    end
    assign read_data_in = d2;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gain(input int peak);
        int g = 0;
        if (peak == 0) return 0;
        for (int s = 0; s < 16; s++) begin
            if ((peak << s) <= 32767) g = s;
        end
        return g;
    endfunction

    function automatic void ref_analyze(output int peak, output int pidx, output int onset,
                                        output int gain, output int silent);
        int m;
        bit found = 0;
        peak = 0; pidx = 0; onset = 0;
        for (int i = 0; i < LEN; i++) begin
            m = (int'(mem[i]) < 0) ? -int'(mem[i]) : int'(mem[i]);
            if (m > peak) begin peak = m; pidx = i; end
        end
        for (int i = 0; i < LEN; i++) begin
            m = (int'(mem[i]) < 0) ? -int'(mem[i]) : int'(mem[i]);
            if (!found && m >= (peak >> 3)) begin onset = i; found = 1; end
        end
        gain   = ref_gain(peak);
        silent = (peak == 0) ? 1 : 0;
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < LEN; i++) mem[i] = 16'(v);
    endtask

    task automatic fill_random(input int amp);
        for (int i = 0; i < LEN; i++) mem[i] = 16'(int'($urandom_range(0, 2 * amp)) - amp);
    endtask

    task automatic pulse_start();
        @(negedge audio_clk) start_in = 1'b1;
        @(posedge audio_clk);
        #1 start_in = 1'b0;
    endtask

    task automatic run_scenario(input string name, input int extra_start_at, input bit start_in_finish);
        int ep, epi, eon, eg, es;
        int n = 0;
        bit addr_ok = 1;
        ref_analyze(ep, epi, eon, eg, es);
        pulse_start();
        check_val({name, ".busy_after_start"}, int'(busy_out), 1);
        check_val({name, ".valid_cleared"}, int'(results_valid_out), 0);
        while (!done_out && n < MAX_CYCLES) begin
            if (n < LEN && int'(read_addr_out) != n) addr_ok = 0;
            start_in = (n == extra_start_at);
            @(posedge audio_clk);
            #1 n++;
        end
        start_in = 1'b0;
        check_val({name, ".done_in_time"}, int'(done_out), 1);
        check_val({name, ".addr_sequence"}, int'(addr_ok), 1);
        check_val({name, ".peak_mag"}, int'(peak_mag_out), ep);
        check_val({name, ".peak_index"}, int'(peak_index_out), epi);
        check_val({name, ".onset_index"}, int'(onset_index_out), eon);
        check_val({name, ".gain_shift"}, int'(gain_shift_out), eg);
        check_val({name, ".silent"}, int'(silent_out), es);
        check_val({name, ".valid_at_done"}, int'(results_valid_out), 1);
        check_val({name, ".busy_at_done"}, int'(busy_out), 0);
        start_in = start_in_finish;
        @(posedge audio_clk);
        #1 start_in = 1'b0;
        check_val({name, ".done_pulse"}, int'(done_out), 0);
        check_val({name, ".idle_after"}, int'(busy_out), 0);
        check_val({name, ".results_held"}, int'(peak_mag_out), ep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gv [6] = '{0, 1, 400, 32767, 16384, 32768};
        bit seen_done;
        rst_in   = 1'b0;
        start_in = 1'b0;
        gsc_mag  = '0;
        fill_const(0);
        #12;
        check_val("reset_state", int'(read_addr_out | peak_mag_out | peak_index_out | onset_index_out
                  | {12'b0, gain_shift_out} | {15'b0, busy_out | done_out | results_valid_out | silent_out}), 0);

        for (int i = 0; i < 26; i++) begin
            gsc_mag = (i < 6) ? 16'(gv[i]) : 16'($urandom_range(0, 65535));
            #1 check_val("gain_calc", int'(gsc_shift), ref_gain(int'(gsc_mag)));
        end

        @(negedge audio_clk) rst_in = 1'b1;

        fill_const(0);
        run_scenario("zero", -1, 1'b0);

        fill_const(10);
        mem[5] = 16'sd100;
        mem[9] = -16'sd400;
        run_scenario("mixed", 5, 1'b0);

        fill_const(0);
        mem[3] = -16'sd32768;
        mem[7] = 16'sd32767;
        run_scenario("fullscale", -1, 1'b1);

        fill_random(1999);
        mem[4]  = 16'sd2000;
        mem[11] = 16'sd2000;
        run_scenario("tie", -1, 1'b0);

        fill_const(0);
        mem[15] = 16'sd1;
        run_scenario("single", -1, 1'b0);

        fill_const(0);
        mem[12] = 16'sd5000;
        pulse_start();
        for (int i = 0; i < 22; i++) begin
            @(posedge audio_clk);
            #1;
        end
        rst_in = 1'b0;
        #2;
        check_val("abort_outputs_zero", int'(read_addr_out | peak_mag_out | peak_index_out | onset_index_out
                  | {12'b0, gain_shift_out} | {15'b0, busy_out | done_out | results_valid_out | silent_out}), 0);
        repeat (2) @(posedge audio_clk);
        @(negedge audio_clk) rst_in = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge audio_clk);
            #1 if (done_out) seen_done = 1;
        end
        check_val("abort_no_done", int'(seen_done), 0);
        run_scenario("restart", -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            fill_random((k % 2 == 0) ? 32768 : 300);
            run_scenario("random", int'($urandom_range(0, 30)), 1'(k % 3 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
